lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that sits between the TRV-32I execute stage and the data memory (`mem_data`). It accepts one RV32I load or store at a time and drives the memory's word-indexed port with the required signals:

- read/write enables
- per-byte write enables
- lane-replicated store data

For loads, it returns sign- or zero-extended data to the pipeline. It also flags misaligned and illegal accesses without touching memory.

## Interface

Parameters:
- `B_WIDTH`, 32: data and byte-address width; fixed at 32 for RV32I.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: pipeline presents a memory operation.
- `req_ready`, output, 1: LSU can accept; high only in IDLE.
- `req_is_store`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RV32I funct3. Encodings: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store source (rs2).
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_rdata`, output, 32: extended load result; 0 for stores and faults.
- `resp_misaligned`, output, 1: alignment fault; valid with `resp_valid`.
- `resp_illegal`, output, 1: unsupported funct3; valid with `resp_valid`.
- `mem_addr`, output, 32: word index, equal to {2'b00, addr[31:2]}.
- `mem_read_en`, output, 1: memory read strobe.
- `mem_write_en`, output, 1: memory write strobe.
- `write_byte_en`, output, 4: per-byte write lanes.
- `mem_wdata`, output, 32: lane-aligned store data.
- `mem_rdata`, input, 32: memory read data, valid the cycle after `mem_read_en`.

## Operation

- **States:** IDLE, MEM_RD, MEM_WAIT, MEM_WR, RESP.
- **Accept:** on a rising edge with `req_valid && req_ready`, the LSU latches addr, funct3, is_store and wdata.
  - Fault checks are performed on the latched values.
  - If both checks fail, both fault bits are set.
- **Fault checks:**
  - Illegal: funct3 is 011, 110 or 111; or a store with funct3 100 or 101.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- **Transitions:**
  - IDLE → RESP on a fault.
  - IDLE → MEM_WR on a store.
  - IDLE → MEM_RD on a load.
  - MEM_RD → MEM_WAIT.
  - MEM_WR → RESP.
  - MEM_WAIT → RESP.
  - RESP → IDLE.
- **Store lanes:**
  - SB: data {4{rs2[7:0]}}, byte_en 4'b0001 << addr[1:0].
  - SH: data {2{rs2[15:0]}}, byte_en 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: data rs2, byte_en 1111.
- **Load extract:**
  - The selected byte or half comes from `mem_rdata >> (8*addr[1:0])`.
  - B and H sign-extend bit 7 or bit 15.
  - BU and HU zero-extend.
  - W passes the word through.
  - `mem_rdata` is captured at the end of MEM_WAIT.
- **Memory strobes:**
  - `mem_read_en` is 1 only in MEM_RD; `mem_write_en` is 1 only in MEM_WR. The two are never both 1.
  - `write_byte_en` is 0 outside MEM_WR.
  - `mem_addr` and `mem_wdata` hold their latched values until the next accept.
- **Responses:**
  - `resp_valid` is 1 only in RESP.
  - `resp_rdata`, `resp_misaligned` and `resp_illegal` are meaningful only while `resp_valid` is 1. They read 0 otherwise.
- **Memory contract:** a faulting request never asserts either memory enable.

## Timing

- All outputs are registered. A is the accept edge; "cycle n" means the n-th cycle after A.
- **Load:** `mem_read_en` high in cycle 1. `resp_valid` high in cycle 3. `req_ready` high again in cycle 4.
- **Store:** `mem_write_en` high in cycle 1. `resp_valid` high in cycle 2. `req_ready` high again in cycle 3.
- **Fault:** `resp_valid` high in cycle 1. `req_ready` high again in cycle 2.
- **Back-to-back:** a request held on `req_valid` is accepted on the first edge where `req_ready` is 1. No request is dropped or accepted twice.
- **Reset:**
  - Asserting `rst` forces IDLE immediately, with all outputs 0, including `req_ready` while `rst` is high.
  - An in-flight operation is aborted and produces no response.
  - A write is suppressed if `rst` rises during MEM_WR.
  - `req_ready` becomes 1 in the first cycle after `rst` deasserts.
- **`req_valid` low in IDLE:** the state holds and outputs are unchanged.

## Test plan

- **SW then LW:** SW addr 0x10, rs2 0xDEADBEEF. Required: cycle 1 `mem_addr`=4, byte_en 1111, `mem_wdata`=0xDEADBEEF. Then LW 0x10 returns 0xDEADBEEF with `resp_valid` exactly 3 cycles after accept.
- **Byte loads:** memory word at index 4 = 0x80FF7F01.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LB 0x11 → 0x0000007F.
  - LB 0x12 → 0xFFFFFFFF.
- **Halves:**
  - SH 0x22, rs2 0x1234ABCD: byte_en 1100, data 0xABCDABCD.
  - LH 0x22 → 0xFFFFABCD.
  - LHU 0x22 → 0x0000ABCD.
- **Faults:**
  - LW 0x11 and SH 0x23: `resp_misaligned`=1 in cycle 1, memory enables never asserted.
  - funct3 011: `resp_illegal`=1.
- **Back-to-back:** `req_valid` held high across an SB followed by an LBU. Required: two accepts with exactly 3 and 4 cycle spacing, and `resp_valid` pulses of one cycle each.
- **Reset mid-operation:** `rst` asserted during MEM_WAIT of an LW. Required: immediate return to all-zero outputs, no `resp_valid`, and `req_ready`=1 in the first cycle after `rst` drops.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: one access at a time against a word-indexed data memory.
// Faulting requests are answered directly without touching memory.
module lsu_mem_port #(
  parameter int B_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_is_store,
  input  logic [2:0]         req_funct3,
  input  logic [B_WIDTH-1:0] req_addr,
  input  logic [B_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  output logic [B_WIDTH-1:0] resp_rdata,
  output logic               resp_misaligned,
  output logic               resp_illegal,
  output logic [B_WIDTH-1:0] mem_addr,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [3:0]         write_byte_en,
  output logic [B_WIDTH-1:0] mem_wdata,
  input  logic [B_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WAIT, MEM_WR, RESP} state_t;

  state_t             r_state, w_next;
  logic               w_accept, w_illegal, w_misaligned, w_fault;
  logic [3:0]         w_be;
  logic [B_WIDTH-1:0] w_lanes, w_shifted, w_load;
  logic [1:0]         r_off;
  logic [2:0]         r_funct3;

  assign w_accept     = req_valid && req_ready;
  assign w_illegal    = (req_funct3 == 3'b011) ||
                        (req_funct3[2] && (req_funct3[1] || req_is_store));
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign w_fault      = w_illegal || w_misaligned;

  always_comb begin
    w_be    = 4'b0000;
    w_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // W is always aligned here, so the shift is a no-op for it.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fault)           w_next = RESP;
          else if (req_is_store) w_next = MEM_WR;
          else                   w_next = MEM_RD;
        end
      end
      MEM_RD:   w_next = MEM_WAIT;
      MEM_WAIT: w_next = RESP;
      MEM_WR:   w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      mem_addr        <= '0;
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      write_byte_en   <= 4'b0000;
      mem_wdata       <= '0;
      r_off           <= 2'b00;
      r_funct3        <= 3'b000;
    end else begin
      req_ready     <= (w_next == IDLE);
      mem_read_en   <= (w_next == MEM_RD);
      mem_write_en  <= (w_next == MEM_WR);
      write_byte_en <= (w_next == MEM_WR) ? w_be : 4'b0000;
      resp_valid    <= (w_next == RESP);
      // Only a faulting accept jumps IDLE -> RESP, so the fault bits come from the live request.
      resp_misaligned <= (w_next == RESP) && (r_state == IDLE) && w_misaligned;
      resp_illegal    <= (w_next == RESP) && (r_state == IDLE) && w_illegal;
      resp_rdata      <= (r_state == MEM_WAIT) ? w_load : '0;
      if (w_accept) begin
        mem_addr  <= {2'b00, req_addr[B_WIDTH-1:2]};
        mem_wdata <= w_lanes;
        r_off     <= req_addr[1:0];
        r_funct3  <= req_funct3;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-level reference model checked every cycle, plus directed
// requests with hand-computed results.
module tb_lsu_mem_port;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_misaligned, resp_illegal;
  logic        mem_read_en, mem_write_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  write_byte_en;

  int n_checks = 0, n_errs = 0, cyc = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.B_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .write_byte_en(write_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT: read data appears the cycle after mem_read_en.
  bit [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_write_en)
      for (int b = 0; b < 4; b++)
        if (write_byte_en[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_read_en) mem_rdata <= mem[mem_addr[5:0]];
  end

  // ---------------- reference model ----------------
  bit [7:0] ref_b [256];

  function automatic int f_size(input bit [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction
  function automatic bit f_ill(input bit st, input bit [2:0] f3);
    return (f3 inside {3'b011, 3'b110, 3'b111}) || (st && (f3 inside {3'b100, 3'b101}));
  endfunction
  function automatic bit f_mis(input bit [2:0] f3, input bit [31:0] a);
    return ((f3 inside {3'b001, 3'b101}) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction
  function automatic bit f_flt(input bit st, input bit [2:0] f3, input bit [31:0] a);
    return f_ill(st, f3) || f_mis(f3, a);
  endfunction
  function automatic int f_len(input bit st, input bit [2:0] f3, input bit [31:0] a);
    return f_flt(st, f3, a) ? 1 : (st ? 2 : 3);
  endfunction
  function automatic bit [3:0] f_be(input bit [2:0] f3, input bit [31:0] a);
    bit [3:0] be = 4'b0000;
    for (int i = 0; i < f_size(f3); i++) be[(int'(a[1:0]) + i) % 4] = 1'b1;
    return be;
  endfunction
  function automatic bit [31:0] f_lanes(input bit [2:0] f3, input bit [31:0] wd);
    bit [31:0] v = '0;
    for (int l = 0; l < 4; l++) v[8*l +: 8] = wd[8*(l % f_size(f3)) +: 8];
    return v;
  endfunction
  function automatic bit [31:0] f_rd(input bit st, input bit [2:0] f3, input bit [31:0] a);
    bit [31:0] v = '0;
    int sz = f_size(f3);
    if (st || f_flt(st, f3, a)) return '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[8'(a[7:0] + 8'(i))];
    if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  bit        m_ready, m_busy, m_st, m_fault, m_mis, m_ill, m_wdchk;
  int        m_k, m_len;
  bit [2:0]  m_f3;
  bit [3:0]  m_be;
  bit [31:0] m_addr, m_wd, m_raw, m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 0; m_busy <= 0; m_k <= 0; m_len <= 0;
      m_addr <= '0; m_wd <= '0; m_wdchk <= 1;
    end else if (m_busy) begin
      m_k <= m_k + 1;
      if (m_k == 1 && m_st && !m_fault)
        for (int i = 0; i < f_size(m_f3); i++) ref_b[8'(m_addr[7:0] + 8'(i))] <= m_raw[8*i +: 8];
      if (m_k == m_len) begin
        m_busy <= 0; m_ready <= 1;
      end
    end else if (m_ready && req_valid) begin
      m_busy <= 1; m_k <= 1; m_ready <= 0;
      m_st <= req_is_store; m_f3 <= req_funct3; m_addr <= req_addr; m_raw <= req_wdata;
      m_fault <= f_flt(req_is_store, req_funct3, req_addr);
      m_mis   <= f_mis(req_funct3, req_addr);
      m_ill   <= f_ill(req_is_store, req_funct3);
      m_len   <= f_len(req_is_store, req_funct3, req_addr);
      m_be    <= f_be(req_funct3, req_addr);
      m_wd    <= f_lanes(req_funct3, req_wdata);
      m_wdchk <= req_is_store && !f_ill(req_is_store, req_funct3);
      m_rdata <= f_rd(req_is_store, req_funct3, req_addr);
    end else begin
      m_ready <= 1;
    end
  end

  always @(negedge clk) begin
    bit rv, rd, wr;
    rv = m_busy && (m_k == m_len);
    rd = m_busy && !m_fault && !m_st && (m_k == 1);
    wr = m_busy && !m_fault && m_st && (m_k == 1);
    chk("req_ready", req_ready, m_ready);
    chk("mem_read_en", mem_read_en, rd);
    chk("mem_write_en", mem_write_en, wr);
    chk("write_byte_en", write_byte_en, wr ? m_be : 4'b0000);
    chk("resp_valid", resp_valid, rv);
    chk("resp_rdata", resp_rdata, rv ? m_rdata : 32'd0);
    chk("resp_misaligned", resp_misaligned, rv && m_mis);
    chk("resp_illegal", resp_illegal, rv && m_ill);
    chk("mem_addr", mem_addr, {2'b00, m_addr[31:2]});
    if (m_wdchk) chk("mem_wdata", mem_wdata, m_wd);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic do_req(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        output bit [31:0] rdv, output bit mis, output bit ill, output int lat,
                        output bit [31:0] c1a, output bit [3:0] c1be, output bit [31:0] c1wd,
                        output bit any_en);
    rdv = '0; mis = 0; ill = 0; lat = 0; c1a = '0; c1be = '0; c1wd = '0; any_en = 0;
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    wait_ready();
    @(negedge clk); #1;
    req_valid = 0;
    c1a = mem_addr; c1be = write_byte_en; c1wd = mem_wdata;
    any_en = mem_read_en | mem_write_en;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk); #1;
      lat++;
      any_en |= mem_read_en | mem_write_en;
    end
    rdv = resp_rdata; mis = resp_misaligned; ill = resp_illegal;
  endtask

  task automatic req_chk(input string nm, input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] e_rd, input bit e_mis,
                         input bit e_ill, input int e_lat);
    bit [31:0] rdv, c1a, c1wd; bit [3:0] c1be; bit mis, ill, en; int lat;
    do_req(st, f3, a, wd, rdv, mis, ill, lat, c1a, c1be, c1wd, en);
    chk({nm, "_rdata"}, rdv, e_rd);
    chk({nm, "_mis"}, 32'(mis), 32'(e_mis));
    chk({nm, "_ill"}, 32'(ill), 32'(e_ill));
    chk({nm, "_latency"}, lat, e_lat);
    if (e_mis || e_ill) chk({nm, "_no_mem_en"}, 32'(en), 0);
  endtask

  initial begin
    bit [31:0] rdv, c1a, c1wd; bit [3:0] c1be; bit mis, ill, en; int lat;
    int acc[3]; int na; int pv[$]; bit [31:0] pd[$]; int cnt;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 0;
    @(negedge clk); #1;
    chk("ready_after_rst", req_ready, 1);

    // SW 0x10 then LW 0x10
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, rdv, mis, ill, lat, c1a, c1be, c1wd, en);
    chk("sw_c1_addr", c1a, 32'd4);
    chk("sw_c1_be", c1be, 4'b1111);
    chk("sw_c1_wdata", c1wd, 32'hDEADBEEF);
    chk("sw_latency", lat, 2);
    req_chk("lw", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 0, 3);

    // byte loads from 0x80FF7F01
    req_chk("sw2", 1, 3'b010, 32'h10, 32'h80FF7F01, 0, 0, 0, 2);
    req_chk("lb13", 0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0, 0, 3);
    req_chk("lbu13", 0, 3'b100, 32'h13, 0, 32'h00000080, 0, 0, 3);
    req_chk("lb11", 0, 3'b000, 32'h11, 0, 32'h0000007F, 0, 0, 3);
    req_chk("lb12", 0, 3'b000, 32'h12, 0, 32'hFFFFFFFF, 0, 0, 3);

    // halves
    do_req(1, 3'b001, 32'h22, 32'h1234ABCD, rdv, mis, ill, lat, c1a, c1be, c1wd, en);
    chk("sh_c1_addr", c1a, 32'd8);
    chk("sh_c1_be", c1be, 4'b1100);
    chk("sh_c1_wdata", c1wd, 32'hABCDABCD);
    req_chk("lh22", 0, 3'b001, 32'h22, 0, 32'hFFFFABCD, 0, 0, 3);
    req_chk("lhu22", 0, 3'b101, 32'h22, 0, 32'h0000ABCD, 0, 0, 3);

    // faults
    req_chk("lw11_mis", 0, 3'b010, 32'h11, 0, 0, 1, 0, 1);
    req_chk("sh23_mis", 1, 3'b001, 32'h23, 32'hFFFF, 0, 1, 0, 1);
    req_chk("f011_ill", 0, 3'b011, 32'h0, 0, 0, 0, 1, 1);
    req_chk("sbu_ill", 1, 3'b100, 32'h4, 32'h1, 0, 0, 1, 1);
    req_chk("shu21_both", 1, 3'b101, 32'h21, 32'h1, 0, 1, 1, 1);

    // back-to-back: SB, LBU, LW with req_valid held high
    wait_ready();
    req_is_store = 1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'h5A; req_valid = 1;
    na = 0;
    for (int s = 0; s < 40 && !(na == 3 && pv.size() >= 3); s++) begin
      if (resp_valid) begin pv.push_back(cyc); pd.push_back(resp_rdata); end
      if (req_valid && req_ready) begin
        acc[na] = cyc + 1;
        na++;
        @(negedge clk); #1;
        if (na == 1) begin req_is_store = 0; req_funct3 = 3'b100; req_addr = 32'h30; end
        else if (na == 2) begin req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h10; end
        else req_valid = 0;
      end else begin
        @(negedge clk); #1;
      end
    end
    req_valid = 0;
    chk("b2b_accepts", na, 3);
    chk("b2b_resps", pv.size(), 3);
    if (na == 3) begin
      chk("b2b_space_sb", acc[1] - acc[0], 3);
      chk("b2b_space_lbu", acc[2] - acc[1], 4);
    end
    if (pv.size() >= 3) begin
      chk("b2b_resp_gap", pv[1] - pv[0], 4);
      chk("b2b_lbu_data", pd[1], 32'h5A);
      chk("b2b_lw_data", pd[2], 32'h80FF7F01);
    end

    // reset during MEM_WAIT of an LW
    wait_ready();
    req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1;
    @(negedge clk); #1;
    req_valid = 0;
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("rstw_ready", req_ready, 0);
    chk("rstw_read_en", mem_read_en, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    cnt = 0;
    repeat (3) begin @(negedge clk); #1; if (resp_valid) cnt++; end
    rst = 0;
    @(negedge clk); #1;
    if (resp_valid) cnt++;
    chk("rstw_no_resp", cnt, 0);
    chk("rstw_ready_after", req_ready, 1);

    // reset during MEM_WR suppresses the write
    req_is_store = 1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h11111111; req_valid = 1;
    @(negedge clk); #1;
    req_valid = 0;
    rst = 1;
    #1;
    chk("rstwr_write_en", mem_write_en, 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    @(negedge clk); #1;
    req_chk("lw_after_rst", 0, 3'b010, 32'h10, 0, 32'h80FF7F01, 0, 0, 3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
